// File: rtl/fwd_hazard_tracker.sv
// Forwarding hazard tracker: keeps shadow copies of the EX/MEM/WB destination
// info, raises per-operand producer match flags for the forwarding muxes, and
// requests a one-cycle stall for load-use and branch-in-ID hazards.
module fwd_hazard_tracker #(
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_load,
  input  logic          id_branch,
  input  logic          flush,
  output logic          idsrc1ex,
  output logic          idsrc1mem,
  output logic          rfd2alueq,
  output logic          rfd2dmbeq,
  output logic          aluaeq,
  output logic          memaeq,
  output logic          alubeq,
  output logic          membeq,
  output logic          stall,
  output logic [CW-1:0] stall_count
);

  // Shadow pipeline state
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_we, ex_load, ex_rs_used, ex_rt_used;
  logic [RW-1:0] mem_rd;
  logic          mem_we, mem_load;
  logic [RW-1:0] wb_rd;
  logic          wb_we;

  // Register 0 is hardwired, so a producer writing it never forwards.
  function automatic logic match(input logic we, input logic [RW-1:0] rd,
                                 input logic [RW-1:0] r);
    return we && (rd != '0) && (rd == r);
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] one;
    one = {{(CW-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Source-versus-producer hits for the ID instruction
  logic id_rs_ex, id_rt_ex, id_rs_mem, id_rt_mem, id_rs_wb, id_rt_wb;
  logic haz_a, haz_b, haz_c, ex_cap;

  // ID operand comparisons against each in-flight producer
  always_comb begin
    id_rs_ex  = id_rs_used & match(ex_we,  ex_rd,  id_rs);
    id_rt_ex  = id_rt_used & match(ex_we,  ex_rd,  id_rt);
    id_rs_mem = id_rs_used & match(mem_we, mem_rd, id_rs);
    id_rt_mem = id_rt_used & match(mem_we, mem_rd, id_rt);
    id_rs_wb  = id_rs_used & match(wb_we,  wb_rd,  id_rs);
    id_rt_wb  = id_rt_used & match(wb_we,  wb_rd,  id_rt);
  end

  // Stall request: load-use, branch vs EX producer, branch vs MEM load
  always_comb begin
    haz_a  = ex_load & (id_rs_ex | id_rt_ex);
    haz_b  = id_branch & (id_rs_ex | id_rt_ex);
    haz_c  = id_branch & mem_load & (id_rs_mem | id_rt_mem);
    stall  = id_valid & (haz_a | haz_b | haz_c);
    ex_cap = id_valid & ~stall & ~flush;
  end

  // Forwarding flags; both of a pair may be set, the consumer prefers MEM
  always_comb begin
    idsrc1ex  = id_valid & id_rs_mem;
    idsrc1mem = id_valid & id_rs_wb;
    rfd2alueq = id_valid & id_rt_mem;
    rfd2dmbeq = id_valid & id_rt_wb;
    aluaeq    = ex_rs_used & match(mem_we, mem_rd, ex_rs);
    memaeq    = ex_rs_used & match(wb_we,  wb_rd,  ex_rs);
    alubeq    = ex_rt_used & match(mem_we, mem_rd, ex_rt);
    membeq    = ex_rt_used & match(wb_we,  wb_rd,  ex_rt);
  end

  // Advance producer info one stage per clock; EX takes a bubble on stall/flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_load    <= 1'b0;
      ex_rs_used <= 1'b0;
      ex_rt_used <= 1'b0;
      mem_rd     <= '0;
      mem_we     <= 1'b0;
      mem_load   <= 1'b0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
    end else begin
      // EX -> MEM -> WB
      wb_rd    <= mem_rd;
      wb_we    <= mem_we;
      mem_rd   <= ex_rd;
      mem_we   <= ex_we;
      mem_load <= ex_load;
      // ID -> EX
      if (ex_cap) begin
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_rd      <= id_rd;
        ex_we      <= id_regwrite;
        ex_load    <= id_load;
        ex_rs_used <= id_rs_used;
        ex_rt_used <= id_rt_used;
      end else begin
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_rd      <= '0;
        ex_we      <= 1'b0;
        ex_load    <= 1'b0;
        ex_rs_used <= 1'b0;
        ex_rt_used <= 1'b0;
      end
    end
  end

  // Saturating stall-cycle counter for performance debug
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker. A second instance with a 4-bit
// counter shares the stimulus so counter saturation is reached quickly.
module tb_fwd_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_load, id_branch, flush;
  logic [4:0] id_rs, id_rt, id_rd;

  logic idsrc1ex, idsrc1mem, rfd2alueq, rfd2dmbeq, aluaeq, memaeq, alubeq, membeq, stall;
  logic [15:0] stall_count;
  logic s_idsrc1ex, s_idsrc1mem, s_rfd2alueq, s_rfd2dmbeq, s_aluaeq, s_memaeq, s_alubeq, s_membeq, s_stall;
  logic [3:0] s_stall_count;

  logic [7:0] fl;
  assign fl = {idsrc1ex, idsrc1mem, rfd2alueq, rfd2dmbeq, aluaeq, memaeq, alubeq, membeq};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_tracker dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_branch(id_branch), .flush(flush),
    .idsrc1ex(idsrc1ex), .idsrc1mem(idsrc1mem), .rfd2alueq(rfd2alueq), .rfd2dmbeq(rfd2dmbeq),
    .aluaeq(aluaeq), .memaeq(memaeq), .alubeq(alubeq), .membeq(membeq),
    .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_tracker #(.RW(5), .CW(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_branch(id_branch), .flush(flush),
    .idsrc1ex(s_idsrc1ex), .idsrc1mem(s_idsrc1mem), .rfd2alueq(s_rfd2alueq), .rfd2dmbeq(s_rfd2dmbeq),
    .aluaeq(s_aluaeq), .memaeq(s_memaeq), .alubeq(s_alubeq), .membeq(s_membeq),
    .stall(s_stall), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the next falling edge (one rising edge has passed), drive ID, settle.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ru, input logic tu, input logic [4:0] rd,
                      input logic we, input logic ld, input logic br, input logic fl_in);
    @(negedge clk);
    id_valid = v;  id_rs = rs;  id_rt = rt;  id_rs_used = ru;  id_rt_used = tu;
    id_rd = rd;  id_regwrite = we;  id_load = ld;  id_branch = br;  flush = fl_in;
    #1;
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_rd = '0; id_regwrite = 1'b0; id_load = 1'b0; id_branch = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_flags", {24'd0, fl}, 32'h00);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_count", {16'd0, stall_count}, 32'd0);

    // ADD r3,r1,r2 ; SUB r5,r3,r3 ; OR r8,r3,r9
    step(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
    chk("add_stall", {31'd0, stall}, 32'd0);
    step(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0, 0, 0);
    chk("sub_id_flags", {24'd0, fl}, 32'h00);
    step(1, 5'd3, 5'd9, 1, 1, 5'd8, 1, 0, 0, 0);
    chk("sub_ex_fwd_mem", {24'd0, fl}, 32'h8A);
    nop();
    chk("or_ex_fwd_wb", {24'd0, fl}, 32'h04);
    repeat (3) nop();
    chk("drain1_flags", {24'd0, fl}, 32'h00);

    // LW r4 ; ADD r6,r4,r1
    step(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0);
    chk("lw_stall", {31'd0, stall}, 32'd0);
    step(1, 5'd4, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
    chk("loaduse_stall", {31'd0, stall}, 32'd1);
    chk("loaduse_cnt0", {16'd0, stall_count}, 32'd0);
    step(1, 5'd4, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
    chk("loaduse_release", {31'd0, stall}, 32'd0);
    chk("loaduse_cnt1", {16'd0, stall_count}, 32'd1);
    chk("loaduse_id_flags", {24'd0, fl}, 32'h80);
    nop();
    chk("loaduse_ex_flags", {24'd0, fl}, 32'h04);
    repeat (3) nop();

    // LW r2 ; BEQ r2,r0
    step(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
    step(1, 5'd2, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
    chk("beq_stall_a", {31'd0, stall}, 32'd1);
    step(1, 5'd2, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
    chk("beq_stall_c", {31'd0, stall}, 32'd1);
    chk("beq_flags_c", {24'd0, fl}, 32'h80);
    step(1, 5'd2, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
    chk("beq_release", {31'd0, stall}, 32'd0);
    chk("beq_flags_wb", {24'd0, fl}, 32'h40);
    chk("beq_count", {16'd0, stall_count}, 32'd3);
    repeat (3) nop();

    // Producer writing r0 (also marked load) never matches
    step(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
    chk("r0_branch_stall", {31'd0, stall}, 32'd0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("r0_mem_flags", {24'd0, fl}, 32'h00);
    step(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("r0_wb_flags", {24'd0, fl}, 32'h00);
    repeat (3) nop();

    // Unused rs does not match; used rt does
    step(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0);
    nop();
    step(1, 5'd7, 5'd7, 0, 1, 5'd0, 0, 0, 0, 0);
    chk("rs_unused_flags", {24'd0, fl}, 32'h20);
    repeat (3) nop();

    // Flushed ADD r7 leaves no r7 producer behind
    step(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0, 1);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    step(1, 5'd7, 5'd7, 1, 1, 5'd0, 0, 0, 1, 0);
    chk("flush_no_ex_r7", {31'd0, stall}, 32'd0);
    nop();
    chk("flush_no_mem_r7", {24'd0, fl}, 32'h00);
    nop();
    chk("flush_no_wb_r7", {24'd0, fl}, 32'h00);
    repeat (2) nop();

    // Flush together with a load-use stall: stall still reported and counted
    step(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0);
    step(1, 5'd9, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1);
    chk("flush_and_stall", {31'd0, stall}, 32'd1);
    nop();
    chk("flush_stall_count", {16'd0, stall_count}, 32'd4);
    repeat (2) nop();

    // Asynchronous reset mid-stream with a pending load-use hazard
    step(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0);
    step(1, 5'd4, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_count", {16'd0, stall_count}, 32'd4);
    rst = 1'b1;
    #1;
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_flags", {24'd0, fl}, 32'h00);
    chk("async_rst_count", {16'd0, stall_count}, 32'd0);
    chk("async_rst_count_s", {28'd0, s_stall_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_bubble", {31'd0, stall}, 32'd0);

    // Repeated LW r1 ; BEQ r1 pairs: two stall cycles each
    for (int k = 0; k < 10; k++) begin
      step(1, 5'd2, 5'd0, 1, 0, 5'd1, 1, 1, 0, 0);
      chk("sat_inject_stall", {31'd0, stall}, 32'd0);
      chk("sat_count", {16'd0, stall_count}, 2 * k);
      chk("sat_count_s", {28'd0, s_stall_count}, (2 * k > 15) ? 15 : 2 * k);
      step(1, 5'd1, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
      chk("sat_stall_a", {31'd0, stall}, 32'd1);
      step(1, 5'd1, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
      chk("sat_stall_c", {31'd0, s_stall}, 32'd1);
    end
    nop();
    chk("sat_final_count", {16'd0, stall_count}, 32'd20);
    chk("sat_final_count_s", {28'd0, s_stall_count}, 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Producer side of the forwarding-select interface: tracks destination registers of in-flight instructions and generates the per-operand match flags consumed by the forwarding select logic, plus the load-use/branch stall request.
- Sits beside the ID/EX/MEM/WB pipeline registers.
- Holds its own shadow copies of EX, MEM and WB destination info.
- Counts stall cycles for performance debug.

Parameters:
- RW, 5, register index width
- CW, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  RW  ID source 1 index
- id_rt  in  RW  ID source 2 index
- id_rs_used  in  1  ID instruction reads rs
- id_rt_used  in  1  ID instruction reads rt
- id_rd  in  RW  ID destination index
- id_regwrite  in  1  ID instruction writes rd
- id_load  in  1  ID instruction is a load
- id_branch  in  1  ID instruction compares operands in ID
- flush  in  1  redirect: squash the ID instruction entering EX
- idsrc1ex  out  1  ID rs matches MEM-stage producer
- idsrc1mem  out  1  ID rs matches WB-stage producer
- rfd2alueq  out  1  ID rt matches MEM-stage producer
- rfd2dmbeq  out  1  ID rt matches WB-stage producer
- aluaeq  out  1  EX rs matches MEM-stage producer
- memaeq  out  1  EX rs matches WB-stage producer
- alubeq  out  1  EX rt matches MEM-stage producer
- membeq  out  1  EX rt matches WB-stage producer
- stall  out  1  hold PC/IF/ID; bubble into EX
- stall_count  out  CW  saturating count of stall cycles

Behaviour:
- State: ex_{rs,rt,rd,we,load,rs_used,rt_used}, mem_{rd,we,load}, wb_{rd,we}. Reset (async, rst=1) clears all to 0. stall_count is also cleared.
- Reset output values: every flag is 0, stall is 0 and stall_count is 0. These values are held while rst=1, independent of the inputs.
- Each posedge when rst=0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID, captured only if id_valid=1 and stall=0 and flush=0. Otherwise EX <= bubble (we=0, load=0, used=0, indices 0).
- Producer validity: a stage producer X "matches" index r when X_we=1, X_rd!=0 and X_rd==r. Register 0 never matches.
- EX flags are combinational from state only:
  - aluaeq = ex_rs_used & match(mem, ex_rs)
  - memaeq = ex_rs_used & match(wb, ex_rs)
  - alubeq and membeq are the same with ex_rt and ex_rt_used.
- ID flags are combinational from ID inputs and state, gated by id_valid:
  - idsrc1ex = id_rs_used & match(mem, id_rs)
  - idsrc1mem = id_rs_used & match(wb, id_rs)
  - rfd2alueq and rfd2dmbeq are the same with rt.
- Both flags of a pair may be 1 together. The consumer gives the MEM-stage (nearer) producer priority. The tracker does not resolve this.
- stall = id_valid & (A | B | C):
  - A (load-use): ex_load, and match(ex, id_rs) with rs_used or match(ex, id_rt) with rt_used.
  - B (branch vs EX ALU producer): id_branch and an EX match on a used source.
  - C (branch vs MEM load): id_branch, mem_load and a MEM match on a used source.
- Stall is single-cycle per hazard. It re-asserts if a hazard remains after the bubble (e.g. load then branch gives 2 stall cycles).
- flush together with stall: EX still gets a bubble, and stall is still reported. Upstream flush wins at the ID register.
- stall_count increments on every posedge with stall=1 and saturates at all-ones.
- Latency: flags are valid in the same cycle as their inputs and the state. Producer info moves one stage per clock.

Test Plan:
- Reset asserted mid-stream with ex_load=1 and matching ID: all outputs go to 0 immediately, with no clock edge needed. After release, EX is a bubble.
- ADD r3 then SUB r5,r3,r3 back-to-back:
  - Next cycle aluaeq=1 and alubeq=1.
  - One cycle later, with SUB moved on, a third instruction reading r3 sees memaeq=1 only.
- LW r4 then ADD r6,r4,r1:
  - stall=1 for exactly 1 cycle and stall_count goes to 1.
  - Then aluaeq=0 and memaeq=1 for ADD in EX.
- LW r2 then BEQ r2,r0:
  - Stall for 2 cycles (A then C), then idsrc1mem=1.
  - stall_count increases by 2.
- Writes to r0 and flags:
  - A producer with rd=0 and we=1 gives all flags 0.
  - An ID instruction with rs_used=0 and rs equal to mem_rd gives idsrc1ex=0.
- flush=1 on the cycle ADD r7 leaves ID: the following cycle has no r7 match in any stage. stall_count saturates at 16'hFFFF under continuous forced stall.
